// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: issues sequential fetches, collects in-order responses and
// presents the oldest filled entry to decode; redirect flushes and discards stale returns.
module prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_inc,
  output logic [31:0] out_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      inc_q   [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    fill_ptr;
  logic [CW-1:0]    count;
  logic [OW-1:0]    outstanding;
  logic [OW-1:0]    drop_cnt;
  logic [31:0]      fetch_pc;
  logic             issue;
  logic             pop;
  logic             rsp_keep;

  // Outputs are muxed straight from queue registers, so a response is visible one edge later.
  assign out_valid     = filled[head];
  assign out_pc        = pc_q[head];
  assign out_pc_inc    = inc_q[head];
  assign out_instr     = instr_q[head];
  assign imem_req_addr = fetch_pc;

  always_comb begin
    imem_req_valid = !rst && !redirect && (outstanding < MAX_C) && (count < DEPTH_C);
    issue          = imem_req_valid && imem_req_ready;
    pop            = out_valid && out_ready && !redirect;
    rsp_keep       = imem_rsp_valid && (drop_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        inc_q[i]   <= '0;
        instr_q[i] <= '0;
      end
      filled      <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
    end else if (redirect) begin
      // Every request still in flight after this edge is stale, including earlier pending drops.
      filled      <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      fetch_pc    <= redirect_pc;
      outstanding <= outstanding - OW'(imem_rsp_valid);
      drop_cnt    <= outstanding - OW'(imem_rsp_valid);
    end else begin
      if (issue) begin
        pc_q[tail]   <= fetch_pc;
        inc_q[tail]  <= fetch_pc + 32'd4;
        filled[tail] <= 1'b0;
        tail         <= tail + PW'(1);
        fetch_pc     <= fetch_pc + 32'd4;
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - OW'(1);
      end
      if (rsp_keep) begin
        instr_q[fill_ptr] <= imem_rsp_data;
        filled[fill_ptr]  <= 1'b1;
        fill_ptr          <= fill_ptr + PW'(1);
      end
      count       <= count + CW'(issue) - CW'(pop);
      outstanding <= outstanding + OW'(issue) - OW'(imem_rsp_valid);
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: cycle table for stall/steady-state, directed redirect cases,
// and a randomized run checked against a sequential-PC stream model with an in-order memory.
module tb_prefetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_inc;
  logic [31:0] out_instr;

  prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  typedef struct {
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req_valid;
  } vec_t;

  req_t        mq[$];
  vec_t        tbl[18];
  int unsigned cyc;
  int unsigned lat_fix;
  int          checks;
  int          errors;
  int          alloc;
  int          pops_total;
  logic [31:0] exp_out;
  logic [31:0] exp_fetch;
  logic        prev_hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        last_pop;
  logic        last_rsp;
  logic        last_ov;
  logic        last_rv;
  logic        last_issue;
  logic [31:0] last_pc;
  logic [31:0] last_inc;
  logic [31:0] last_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle: memory response, then samples at negedge and updates the stream model.
  task automatic run_cycle();
    logic        issue_now;
    logic        pop_now;
    int unsigned lat;
    imem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? memf(mq[0].addr) : 32'h0;
    @(negedge clk);
    assert (!(imem_rsp_valid && mq.size() == 0));
    issue_now = imem_req_valid && imem_req_ready;
    pop_now   = out_valid && out_ready && !redirect;
    if (prev_hold) begin
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_instr", out_instr, hold_instr);
    end
    prev_hold  = out_valid && !out_ready && !redirect;
    hold_pc    = out_pc;
    hold_instr = out_instr;
    if (imem_req_valid)
      chk("req_legal", 32'(!redirect && (mq.size() < int'(MAXO)) && (alloc < int'(DEPTH))), 32'h1);
    if (pop_now) begin
      chk("out_pc", out_pc, exp_out);
      chk("out_pc_inc", out_pc_inc, exp_out + 32'd4);
      chk("out_instr", out_instr, memf(exp_out));
      exp_out = exp_out + 32'd4;
      alloc--;
      pops_total++;
    end
    if (imem_rsp_valid) void'(mq.pop_front());
    if (issue_now) begin
      chk("req_addr", imem_req_addr, exp_fetch);
      lat = (lat_fix != 0) ? lat_fix : $urandom_range(8, 1);
      mq.push_back('{imem_req_addr, cyc + lat});
      exp_fetch = exp_fetch + 32'd4;
      alloc++;
    end
    if (redirect) begin
      exp_out   = redirect_pc;
      exp_fetch = redirect_pc;
      alloc     = 0;
    end
    last_pop   = pop_now;
    last_rsp   = imem_rsp_valid;
    last_ov    = out_valid;
    last_rv    = imem_req_valid;
    last_issue = issue_now;
    last_pc    = out_pc;
    last_inc   = out_pc_inc;
    last_instr = out_instr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;
    mq.delete();
    exp_out   = RPC;
    exp_fetch = RPC;
    alloc     = 0;
    prev_hold = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc_inc", out_pc_inc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_pop(input int bound, output logic got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      run_cycle();
      got = last_pop;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        got;
    logic        found;
    logic [31:0] r;
    int          n;
    rst        = 1'b1;
    checks     = 0;
    errors     = 0;
    pops_total = 0;
    lat_fix    = 1;
    cyc        = 0;

    // Latency 1: stall for 10 cycles with 4 entries filling, then release and stream.
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h00, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 32'h00, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'h00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h00, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h00, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h00, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 32'h04, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 32'h08, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 32'h0C, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'h10, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'h14, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 32'h18, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 32'h1C, 1'b1};

    #1;
    do_reset();
    imem_req_ready = 1'b1;
    lat_fix        = 1;
    for (int i = 0; i < 18; i++) begin
      out_ready = tbl[i].out_ready;
      run_cycle();
      chk($sformatf("tbl%0d_out_valid", i), 32'(last_ov), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_req_valid", i), 32'(last_rv), 32'(tbl[i].exp_req_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_out_pc", i), last_pc, tbl[i].exp_pc);
    end

    // Redirect with requests for 8 and 12 in flight.
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    lat_fix        = 6;
    found          = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() == 2 && mq[0].addr == 32'h8 && mq[1].addr == 32'hC && mq[0].due > cyc) begin
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        found       = 1'b1;
      end
      run_cycle();
      redirect = 1'b0;
    end
    chk("flush2_setup", 32'(found), 32'h1);
    wait_pop(40, got);
    chk("flush2_pop_seen", 32'(got), 32'h1);
    if (got) begin
      chk("flush2_pc", last_pc, 32'h100);
      chk("flush2_pc_inc", last_inc, 32'h104);
    end

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    lat_fix        = 1;
    repeat (8) run_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    run_cycle();
    redirect = 1'b0;
    chk("coincide_rsp_and_valid", 32'({last_rsp, last_ov}), 32'h3);
    wait_pop(30, got);
    chk("coincide_pop_seen", 32'(got), 32'h1);
    if (got) chk("coincide_pc", last_pc, 32'h200);

    // Back-to-back redirects with latency 5, then confirm full issue capacity recovers.
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    lat_fix        = 5;
    repeat (4) run_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    run_cycle();
    redirect_pc = 32'h80;
    run_cycle();
    redirect = 1'b0;
    wait_pop(60, got);
    chk("b2b_pop_seen", 32'(got), 32'h1);
    if (got) chk("b2b_pc", last_pc, 32'h80);
    repeat (20) run_cycle();
    imem_req_ready = 1'b0;
    repeat (30) run_cycle();
    lat_fix        = 20;
    imem_req_ready = 1'b1;
    n = 0;
    repeat (4) begin
      run_cycle();
      if (last_issue) n++;
    end
    chk("b2b_reissue_count", 32'(n), 32'(MAXO));

    // Randomized traffic: latency 1-8, random readiness, ~5% redirects.
    do_reset();
    lat_fix    = 0;
    pops_total = 0;
    for (int i = 0; i < 10000; i++) begin
      imem_req_ready = ($urandom_range(9, 0) < 7);
      out_ready      = ($urandom_range(9, 0) < 7);
      redirect       = ($urandom_range(99, 0) < 5);
      if (redirect) begin
        r           = $urandom();
        redirect_pc = r & 32'hFFFF_FFFC;
      end
      run_cycle();
    end
    redirect = 1'b0;
    chk("random_progress", 32'(pops_total > 500), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum issued-but-unreturned imem requests (1..DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port redirect  in  1  flush the queue and restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  in  32  new fetch address, word aligned.
REQ-008 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-009 SHALL have port imem_req_ready  in  1  memory accepts the request.
REQ-010 SHALL have port imem_req_addr  out  32  request byte address.
REQ-011 SHALL have port imem_rsp_valid  in  1  in-order response valid, latency >=1 cycle, unbounded.
REQ-012 SHALL have port imem_rsp_data  in  32  returned instruction word.
REQ-013 SHALL have port out_valid  out  1  head instruction available to decode.
REQ-014 SHALL have port out_ready  in  1  decode accepts the head (deassert = stall).
REQ-015 SHALL have ports out_pc, out_pc_inc, out_instr  out  32 each  head PC, PC+4, instruction.

Function
REQ-016 SHALL hold fetch_pc; handshake imem_req_valid && imem_req_ready issues fetch_pc and advances fetch_pc by 4 (mod 2^32).
REQ-017 SHALL drive imem_req_addr = fetch_pc and assert imem_req_valid only when !redirect, outstanding < MAX_OUTSTANDING, and allocated entries < DEPTH.
REQ-018 SHALL allocate a queue entry at issue, storing the PC with filled=0; a queue entry is held from issue until popped.
REQ-019 SHALL write a non-discarded response into the oldest unfilled entry and set filled=1; responses have no ID and are matched by order only.
REQ-020 SHALL assert out_valid iff the head entry is filled; out_pc/out_instr come from the head and out_pc_inc = out_pc + 4.
REQ-021 SHALL pop the head on out_valid && out_ready; outputs are stable while out_valid && !out_ready.
REQ-022 SHALL deliver the first instruction no earlier than one cycle after the response edge (registered output, no combinational rsp->out path).
REQ-023 SHALL support same-cycle issue, fill and pop; pointers wrap modulo DEPTH and counters stay exact.
REQ-024 On redirect, SHALL in the same edge empty the queue, load fetch_pc = redirect_pc, and set drop_cnt = outstanding - imem_rsp_valid.
REQ-025 The response arriving in the redirect cycle SHALL be discarded, and no pop SHALL occur in that cycle.
REQ-026 While drop_cnt > 0, each response SHALL be discarded and decrement drop_cnt; issue of new requests SHALL continue within MAX_OUTSTANDING.
REQ-027 Redirect while drop_cnt > 0 SHALL retain pending drops: drop_cnt = outstanding - imem_rsp_valid, which includes the stale requests.
REQ-028 outstanding SHALL equal issued minus returned responses, including discarded responses, and never exceed MAX_OUTSTANDING.
REQ-029 imem_rsp_valid with outstanding == 0 is illegal (bench assertion); the design need not handle it.

Reset
REQ-030 On rst, SHALL asynchronously set fetch_pc = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, out_valid = 0, imem_req_valid = 0, and out_pc/out_pc_inc/out_instr = 0.
REQ-031 After rst deasserts, SHALL issue the first request at RESET_PC on the first clock edge without reset.
REQ-032 Reset mid-operation SHALL abandon in-flight requests; the bench SHALL reset the memory model together with the block.

Verification
REQ-033 Scenario: RESET_PC=0, latency 1, out_ready=1 -> out_pc sequence 0,4,8,..., out_instr equals memory words, and a new instruction every cycle in steady state.
REQ-034 Scenario: out_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 entries allocated, imem_req_valid=0, outputs held at pc 0; release -> pcs 0,4,8,12,16 with none lost or duplicated.
REQ-035 Scenario: 2 requests outstanding at pcs 8 and 12, redirect to 0x100 -> both responses dropped, the next accepted out_pc = 0x100, and out_pc_inc = 0x104.
REQ-036 Scenario: redirect in the same cycle as a response and a pop -> that response is discarded, drop_cnt = outstanding-1, and no stale pc reaches the output.
REQ-037 Scenario: back-to-back redirects to 0x40 then 0x80 with latency 5 -> only pcs >= 0x80 are delivered, and outstanding returns to 0.
REQ-038 Scenario: random latency 1-8, random ready/out_ready, and 5% redirects for 10k cycles -> scoreboard delivers the exact PC/instr stream with no overflow and outstanding <= MAX_OUTSTANDING.
